// File: rtl/adc_capture_buffer.sv
// Triggered multi-channel capture into circular block RAM with programmable pre-trigger depth.
// Records are read back by logical offset from the oldest retained beat.
module adc_capture_buffer #(
  parameter int NCHAN  = 8,
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NCHAN*DATA_W-1:0] s_axis_tdata,
  input  logic [NCHAN-1:0]        s_axis_tvalid,
  output logic [NCHAN-1:0]        s_axis_tready,
  input  logic                    arm,
  input  logic                    trig,
  input  logic [ADDR_W:0]         pretrig,
  output logic                    busy,
  output logic                    done,
  output logic                    misalign,
  output logic [ADDR_W-1:0]       trig_addr,
  output logic [ADDR_W-1:0]       start_addr,
  input  logic                    rd_en,
  input  logic [CHAN_W-1:0]       rd_chan,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   MAX_PRE = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_wr_ptr;
  logic [ADDR_W:0]           r_cnt;
  logic [ADDR_W-1:0]         r_pre;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_misalign;
  logic [ADDR_W-1:0]         r_trig_addr;
  logic [ADDR_W-1:0]         r_start_addr;

  logic [NCHAN*DATA_W-1:0]   r_mem [DEPTH];
  logic [NCHAN*DATA_W-1:0]   r_rd_row;
  logic                      r_rd_v1;
  logic [CHAN_W-1:0]         r_rd_ch1;
  logic                      r_rd_valid;
  logic [DATA_W-1:0]         r_rd_data;

  logic                      w_beat;
  logic                      w_partial;
  logic [ADDR_W-1:0]         w_pre_clamp;
  logic [ADDR_W:0]           w_post_len;
  logic                      w_post_full;
  logic                      w_we;
  logic                      w_rd_fire;
  logic [ADDR_W-1:0]         w_rd_phys;
  logic [DATA_W-1:0]         w_rd_sel;

  assign s_axis_tready = {NCHAN{1'b1}};
  assign busy          = r_busy;
  assign done          = r_done;
  assign misalign      = r_misalign;
  assign trig_addr     = r_trig_addr;
  assign start_addr    = r_start_addr;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;

  assign w_beat      = &s_axis_tvalid;
  assign w_partial   = (|s_axis_tvalid) & ~w_beat;
  assign w_pre_clamp = (pretrig > MAX_PRE) ? MAX_PRE[ADDR_W-1:0] : pretrig[ADDR_W-1:0];
  assign w_post_len  = DEPTH_L - {1'b0, r_pre};
  // POST spends one beat-free cycle noticing the record is complete, so P == 1 still works
  assign w_post_full = (r_cnt == w_post_len);
  assign w_we        = w_beat && !arm &&
                       ((r_state == S_FILL) || (r_state == S_ARMED) ||
                        ((r_state == S_POST) && !w_post_full));
  assign w_rd_fire   = rd_en && (r_state == S_DONE);
  assign w_rd_phys   = r_start_addr + rd_addr;

  // Capture FSM with write pointer, beat counter and registered status outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_pre        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_misalign   <= 1'b0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (arm) r_misalign <= 1'b0;
      else if (w_partial && r_busy) r_misalign <= 1'b1;
      if (arm) begin
        r_pre    <= w_pre_clamp;
        r_wr_ptr <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
        r_state  <= (w_pre_clamp == '0) ? S_ARMED : S_FILL;
      end else begin
        case (r_state)
          S_FILL: begin
            if (w_beat) begin
              r_cnt <= r_cnt + CNT_ONE;
              if ((r_cnt + CNT_ONE) == {1'b0, r_pre}) r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (trig) begin
              r_state     <= S_POST;
              r_trig_addr <= r_wr_ptr;
              r_cnt       <= w_beat ? CNT_ONE : '0;
            end
          end
          S_POST: begin
            if (w_post_full) begin
              r_state      <= S_DONE;
              r_start_addr <= r_wr_ptr;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end else if (w_beat) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  // Sample RAM: full-width row per address, registered read port
  always_ff @(posedge aclk) begin
    if (w_we) r_mem[r_wr_ptr] <= s_axis_tdata;
    if (w_rd_fire) r_rd_row <= r_mem[w_rd_phys];
  end

  // Channel select from the registered RAM row
  always_comb begin
    w_rd_sel = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (r_rd_ch1 == CHAN_W'(c)) w_rd_sel = r_rd_row[c*DATA_W +: DATA_W];
      else w_rd_sel = w_rd_sel;
    end
  end

  // Two-stage read pipeline; rd_data holds between valid beats
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_v1    <= 1'b0;
      r_rd_ch1   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_v1    <= w_rd_fire;
      r_rd_ch1   <= rd_chan;
      r_rd_valid <= r_rd_v1;
      if (r_rd_v1) r_rd_data <= w_rd_sel;
    end
  end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Scoreboard bench for adc_capture_buffer: channel c beat n carries c*1000+n, records
// are read back by logical offset and compared against values predicted from the stimulus.
module tb_adc_capture_buffer;
  localparam int NCHAN  = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CHAN_W = 2;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [NCHAN*DATA_W-1:0] s_axis_tdata = '0;
  logic [NCHAN-1:0]        s_axis_tvalid = '0;
  logic [NCHAN-1:0]        s_axis_tready;
  logic                    arm = 1'b0;
  logic                    trig = 1'b0;
  logic [ADDR_W:0]         pretrig = '0;
  logic                    busy, done, misalign;
  logic [ADDR_W-1:0]       trig_addr, start_addr;
  logic                    rd_en = 1'b0;
  logic [CHAN_W-1:0]       rd_chan = '0;
  logic [ADDR_W-1:0]       rd_addr = '0;
  logic                    rd_valid;
  logic [DATA_W-1:0]       rd_data;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DATA_W-1:0] exp_q [$];

  adc_capture_buffer #(.NCHAN(NCHAN), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .arm(arm), .trig(trig), .pretrig(pretrig),
    .busy(busy), .done(done), .misalign(misalign),
    .trig_addr(trig_addr), .start_addr(start_addr),
    .rd_en(rd_en), .rd_chan(rd_chan), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 aclk = ~aclk;

  task automatic step(input logic [NCHAN-1:0] v, input int n, input logic a, input logic t);
    for (int c = 0; c < NCHAN; c++) s_axis_tdata[c*DATA_W +: DATA_W] = 16'(c*1000 + n);
    s_axis_tvalid = v;
    arm = a;
    trig = t;
    @(negedge aclk);
  endtask

  task automatic read_record(input int ch, input int first_n, input bit expect_v);
    bit e0, e1, en;
    logic [DATA_W-1:0] want, last;
    e0 = 1'b0; e1 = 1'b0; last = '0;
    for (int i = 0; i < 18; i++) begin
      tests_run++;
      if (rd_valid !== e1) begin
        tests_failed++;
        $display("FAIL rd_valid_latency ch%0d step%0d: got %b want %b", ch, i, rd_valid, e1);
      end
      if (rd_valid === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rd_unexpected ch%0d step%0d: got %0d, nothing expected", ch, i, rd_data);
        end else begin
          want = exp_q.pop_front();
          if (rd_data !== want) begin
            tests_failed++;
            $display("FAIL rd_data ch%0d step%0d: got %0d want %0d", ch, i, rd_data, want);
          end
        end
      end
      en = (i < 16);
      rd_en = en;
      rd_chan = 2'(ch);
      rd_addr = 4'(i);
      if (en && expect_v) begin
        last = 16'(ch*1000 + first_n + i);
        exp_q.push_back(last);
      end
      e1 = e0;
      e0 = en && expect_v;
      @(negedge aclk);
    end
    tests_run++;
    if (rd_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rd_drain ch%0d: rd_valid %b pending %0d, want 0 and 0", ch, rd_valid, exp_q.size());
      exp_q.delete();
    end
    if (expect_v) begin
      tests_run++;
      if (rd_data !== last) begin
        tests_failed++;
        $display("FAIL rd_data_hold ch%0d: got %0d want %0d", ch, rd_data, last);
      end
    end
  endtask

  task automatic capture(input int pre_req, input int trig_at, input int early_trig,
                         input int partial_at, input int gap_period);
    int n, cyc, pre_c;
    bit part_done;
    n = 0; cyc = 0; part_done = 1'b0;
    pre_c = (pre_req > DEPTH-1) ? DEPTH-1 : pre_req;
    pretrig = 5'(pre_req);
    step(4'h0, 0, 1'b1, 1'b0);
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL arm_status: busy %b done %b, want 1 0", busy, done);
    end
    tests_run++;
    if (misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL arm_clears_misalign: got %b want 0", misalign);
    end
    while (done !== 1'b1 && cyc < 400) begin
      cyc++;
      if (gap_period > 0 && (cyc % gap_period) == 0) begin
        step(4'h0, n, 1'b0, 1'b0);
      end else if (n == partial_at && !part_done) begin
        tests_run++;
        if (misalign !== 1'b0) begin
          tests_failed++;
          $display("FAIL misalign_early: got %b want 0", misalign);
        end
        step(4'b0111, n + 500, 1'b0, 1'b0);
        part_done = 1'b1;
        tests_run++;
        if (misalign !== 1'b1) begin
          tests_failed++;
          $display("FAIL misalign_set: got %b want 1", misalign);
        end
      end else begin
        step(4'hF, n, 1'b0, (n == trig_at) || (n == early_trig));
        if (n == early_trig) begin
          tests_run++;
          if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_trig_ignored: busy %b done %b, want 1 0", busy, done);
          end
        end
        n++;
      end
    end
    s_axis_tvalid = '0;
    trig = 1'b0;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL capture_done: done %b busy %b, want 1 0", done, busy);
    end
    tests_run++;
    if (trig_addr !== 4'(trig_at)) begin
      tests_failed++;
      $display("FAIL trig_addr: got %0d want %0d", trig_addr, 4'(trig_at));
    end
    tests_run++;
    if (start_addr !== 4'(trig_at - pre_c)) begin
      tests_failed++;
      $display("FAIL start_addr: got %0d want %0d", start_addr, 4'(trig_at - pre_c));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    tests_run++;
    if ({busy, done, misalign, rd_valid} !== 4'b0000 || trig_addr !== 4'd0 ||
        start_addr !== 4'd0 || rd_data !== 16'd0 || s_axis_tready !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_state: busy %b done %b mis %b rv %b ta %0d sa %0d rd %0d rdy %h",
               busy, done, misalign, rd_valid, trig_addr, start_addr, rd_data, s_axis_tready);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    read_record(1, 0, 1'b0);
  endtask

  task automatic test_basic();
    capture(4, 100, -1, -1, 0);
    read_record(0, 96, 1'b1);
    read_record(2, 96, 1'b1);
  endtask

  task automatic test_pretrig_zero();
    capture(0, 7, -1, -1, 0);
    read_record(1, 7, 1'b1);
    read_record(3, 7, 1'b1);
  endtask

  task automatic test_early_trig();
    capture(4, 50, 2, -1, 0);
    read_record(0, 46, 1'b1);
  endtask

  task automatic test_misalign();
    capture(4, 40, -1, 30, 7);
    tests_run++;
    if (misalign !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign_sticky: got %b want 1", misalign);
    end
    read_record(3, 36, 1'b1);
  endtask

  task automatic test_clamp();
    capture(21, 60, -1, -1, 0);
    read_record(0, 45, 1'b1);
    read_record(2, 45, 1'b1);
  endtask

  task automatic test_reset_mid();
    pretrig = 5'd4;
    step(4'h0, 0, 1'b1, 1'b0);
    for (int n = 0; n < 24; n++) step(4'hF, n, 1'b0, n == 20);
    s_axis_tvalid = '0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_busy: busy %b done %b, want 1 0", busy, done);
    end
    #2 aresetn = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, rd_valid} !== 3'b000 || trig_addr !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy %b done %b rv %b ta %0d, want 0 0 0 0", busy, done, rd_valid, trig_addr);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    read_record(0, 0, 1'b0);
    tests_run++;
    if (rd_data !== 16'd0) begin
      tests_failed++;
      $display("FAIL rd_after_reset: got %0d want 0", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pretrig_zero();
    test_early_trig();
    test_misalign();
    test_clamp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
